// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES job arbiter: FSM states, key-size
// mode encodings and the round count each mode needs.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [3:0] ROUNDS_128 = 4'd10;
    localparam logic [3:0] ROUNDS_192 = 4'd12;
    localparam logic [3:0] ROUNDS_256 = 4'd14;

    // The illegal mode never reaches the core, so its round count is don't-care.
    function automatic logic [3:0] mode_to_rounds(input logic [1:0] mode);
        case (mode)
            MODE_128: return ROUNDS_128;
            MODE_192: return ROUNDS_192;
            MODE_256: return ROUNDS_256;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping around. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one round-iterative AES core between NUM_REQ requesters: round-robin
// job acceptance, launch with watchdog, and a single response port.
module aes_job_arbiter import aes_arb_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 128,
    parameter int KEY_W       = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_enc_dec,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    output logic                       core_start,
    output logic                       core_enc_dec,
    output logic [1:0]                 core_mode,
    output logic [3:0]                 core_round_amount,
    output logic [DATA_W-1:0]          core_data,
    output logic [KEY_W-1:0]           core_key,
    output logic                       core_flush,
    input  logic                       core_done,
    input  logic [DATA_W-1:0]          core_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_error,
    output logic [1:0]                 dbg_state,
    output logic [$clog2(NUM_REQ)-1:0] dbg_ptr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_valid;
    logic [WD_W-1:0]    wdog;
    logic               timeout_hit;
    logic               grant_fire;

    logic [1:0]        mode_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [KEY_W-1:0]  key_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mode_arr[i] = req_mode[2*i +: 2];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
        assign key_arr[i]  = req_key[i*KEY_W +: KEY_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .ptr         (ptr),
        .req         (req_valid),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign timeout_hit = (wdog == WD_W'(TIMEOUT_CYC - 1));
    assign grant_fire  = (state == IDLE) && grant_valid;
    assign dbg_state   = state;
    assign dbg_ptr     = ptr;

    // Valid/ready: a transfer happens on any cycle where both are high. req_ready
    // is only offered in IDLE; rsp_valid holds its payload until rsp_ready.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        core_flush = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready = grant_oh;
                    if (mode_arr[grant_idx] == MODE_ILLEGAL) state_nxt = RESP;
                    else                                     state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = BUSY;
            end
            BUSY: begin
                if (core_done) begin
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    core_flush = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            ptr               <= '0;
            wdog              <= '0;
            core_enc_dec      <= 1'b0;
            core_mode         <= '0;
            core_round_amount <= '0;
            core_data         <= '0;
            core_key          <= '0;
            rsp_id            <= '0;
            rsp_data          <= '0;
            rsp_error         <= 1'b0;
        end else begin
            state <= state_nxt;
            // Core payload is held until the next grant; the core reads direction live.
            if (grant_fire) begin
                ptr               <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
                core_enc_dec      <= req_enc_dec[grant_idx];
                core_mode         <= mode_arr[grant_idx];
                core_round_amount <= mode_to_rounds(mode_arr[grant_idx]);
                core_data         <= data_arr[grant_idx];
                core_key          <= key_arr[grant_idx];
                rsp_id            <= grant_idx;
                rsp_data          <= '0;
                rsp_error         <= (mode_arr[grant_idx] == MODE_ILLEGAL);
            end
            if (state == LAUNCH) wdog <= '0;
            if (state == BUSY) begin
                wdog <= wdog + WD_W'(1);
                if (core_done) begin
                    rsp_data  <= core_result;
                    rsp_error <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Shares one AES round-iterative core between NUM_REQ independent requesters.
- Accepts jobs (key, block, mode, direction) on per-requester valid/ready ports and picks one round-robin.
- Launches the job on the core with a start pulse, then waits for the core's done with a watchdog.
- Returns the result with the requester ID on a single valid/ready response port. Sits between the bus-side job queues and the AES core FSM/datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 128, block width
- KEY_W, 256, key width; shorter keys are left-aligned (MSBs)
- TIMEOUT_CYC, 1024, max cycles from core_start to core_done before abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester job accept (one-hot or zero)
- req_enc_dec  in  NUM_REQ  0=encrypt, 1=decrypt
- req_mode  in  2*NUM_REQ  00=AES128, 01=AES192, 10=AES256, 11=illegal
- req_data  in  NUM_REQ*DATA_W  input blocks, requester i at slice i
- req_key  in  NUM_REQ*KEY_W  keys, requester i at slice i
- core_start  out  1  one-cycle launch pulse
- core_enc_dec  out  1  registered direction, stable for the whole job
- core_mode  out  2  registered mode, stable for the whole job
- core_round_amount  out  4  10/12/14 from mode
- core_data  out  DATA_W  registered block
- core_key  out  KEY_W  registered key
- core_flush  out  1  one-cycle pulse on watchdog abort; drives the core's reset
- core_done  in  1  core completion pulse
- core_result  in  DATA_W  core output, valid when core_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_data  out  DATA_W  result; zero when rsp_error=1
- rsp_error  out  1  1 = illegal mode or timeout

Behaviour:
- Reset:
  - State goes to IDLE and the RR pointer to 0.
  - All outputs go to 0: req_ready, core_start, core_flush, rsp_valid, rsp_error, rsp_id, rsp_data, and the core_* payload registers.
  - Reset mid-job aborts silently. core_flush is not pulsed, because the core shares the reset.
- FSM states: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - If any req_valid, the grant g is the first set bit at or after the pointer, with wrap-around.
  - req_ready[g]=1 combinationally this cycle. The payload is latched at the clock edge and the pointer becomes (g+1) mod NUM_REQ.
  - Mode 11: go to RESP with rsp_error=1 and rsp_data=0. No core launch.
  - Otherwise go to LAUNCH.
- LAUNCH: core_start=1 for exactly one cycle; the watchdog clears to 0; go to BUSY.
- BUSY:
  - The watchdog increments each cycle.
  - core_done=1: latch core_result into rsp_data, rsp_error=0, go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT_CYC-1: core_flush=1 for one cycle, rsp_error=1, rsp_data=0, go to RESP.
  - core_done on the same cycle as the timeout takes priority (success).
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_error are held stable until rsp_ready.
  - On the rsp_valid&rsp_ready cycle go to IDLE.
  - No new grant is issued in that same cycle; the next grant is earliest one cycle later.
- core_done outside BUSY is ignored.
- core_enc_dec, core_mode, core_key and core_data change only at a grant edge. They are held until the next grant, because the core samples direction combinationally.
- Latency:
  - Grant at cycle T, core_start at T+1.
  - If core_done arrives at T+1+K, rsp_valid is asserted from T+2+K.
  - Illegal mode: rsp_valid at T+1.
- req_ready is never asserted outside IDLE. At most one job is in flight.
- Round amount: 00→10, 01→12, 10→14, registered with the mode.

Decomposition:
- Package aes_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, BUSY, RESP)
  - mode encodings MODE_128/192/256/ILLEGAL
  - round constants 10/12/14 and a mode_to_rounds function
- One sub-module, rr_arbiter: a parameterised round-robin grant with pointer input, request vector in, one-hot grant and index out. Purely combinational; the pointer register lives in aes_job_arbiter.

Test Plan:
1. Single encrypt: req_valid=0001, mode 00, FIPS-197 key 000102..0f, pt 00112233..ff; core model returns done after 176 cycles → rsp_valid at T+178, rsp_id=0, rsp_data=69c4e0d8..c55a, rsp_error=0.
2. Fairness: req_valid=1111 held, rsp_ready=1 → grant order 0,1,2,3,0; each req_ready pulse lasts one cycle; exactly one core_start per job.
3. Illegal mode: requester 2, mode 11 → no core_start; rsp_valid one cycle after grant with rsp_id=2, rsp_error=1, rsp_data=0.
4. Timeout: core never asserts done → core_flush pulse TIMEOUT_CYC cycles after core_start, then rsp_error=1; next job launches normally.
5. Backpressure and reset: hold rsp_ready=0 for 20 cycles → rsp fields stable and req_ready=0 throughout; then assert reset during BUSY → all outputs 0 next cycle and pointer=0.
